neuron_mac_gen: RTL and testbench
=================================

NEURON_MAC_GEN -- requirements
Module: neuron_mac_gen

Interface
REQ-001 Parameter LAYER_NO, default 1: layer index this neuron answers to on the config bus.
REQ-002 Parameter NEURON_NO, default 0: neuron index this neuron answers to on the config bus.
REQ-003 Parameter NUM_WEIGHT, default 30: number of inputs and weights per inference, >=1.
REQ-004 Parameter DATA_WIDTH, default 16: signed width of inputs, weights, bias and output.
REQ-005 Parameter FRAC_BITS, default 8: fractional bits of the DATA_WIDTH fixed-point format.
REQ-006 Port clk, input, 1: single clock; all logic on rising edge.
REQ-007 Port rst, input, 1: reset, synchronous, active-low.
REQ-008 Port weight_valid, input, 1: weight write strobe.
REQ-009 Port bias_valid, input, 1: bias write strobe.
REQ-010 Port weight_value, input, 32: weight word; low DATA_WIDTH bits used.
REQ-011 Port bias_value, input, 32: bias word; low DATA_WIDTH bits used.
REQ-012 Port config_layer_num, input, 32: target layer of the current write.
REQ-013 Port config_neuron_num, input, 32: target neuron of the current write.
REQ-014 Port act_sel, input, 1: 0 selects ReLU, 1 selects linear; sampled when the result is registered.
REQ-015 Port in_data, input, DATA_WIDTH: signed activation input.
REQ-016 Port in_valid, input, 1: in_data is valid.
REQ-017 Port in_ready, output, 1: the neuron accepts input this cycle.
REQ-018 Port out_data, output, DATA_WIDTH: signed neuron result.
REQ-019 Port out_valid, output, 1: out_data is valid.
REQ-020 Port out_ready, input, 1: downstream consumes out_data.

Function
REQ-021 A write SHALL occur only when its strobe is high, config_layer_num==LAYER_NO and config_neuron_num==NEURON_NO; otherwise no write occurs.
REQ-022 Weight writes SHALL store weights at addresses 0..NUM_WEIGHT-1; the write pointer increments per write and wraps to 0 after NUM_WEIGHT-1.
REQ-023 A bias write SHALL replace the bias register; writes are legal in any state and take effect at the next BIAS state.
REQ-024 The FSM SHALL have exactly five states: IDLE, ACCUM, DRAIN, BIAS, OUT.
REQ-025 IDLE->ACCUM SHALL occur on the first accepted input.
REQ-026 ACCUM->DRAIN SHALL occur on acceptance of input NUM_WEIGHT-1, counting inputs from 0.
REQ-027 DRAIN SHALL last 2 cycles, then go to BIAS; BIAS SHALL last 1 cycle, then go to OUT.
REQ-028 OUT->IDLE SHALL occur when out_valid and out_ready are both high.
REQ-029 in_ready SHALL be 1 in IDLE and ACCUM and 0 otherwise; an input is accepted when in_valid and in_ready are both high.
REQ-030 The pipeline SHALL register each product in_data*weight[count] as signed 2*DATA_WIDTH one cycle after acceptance, and add it to the accumulator on the next cycle.
REQ-031 Every accumulator add, including the bias add, SHALL saturate: a signed overflow clamps to 0x7FF..F (positive) or 0x800..0 (negative).
REQ-032 The BIAS state SHALL add the sign-extended bias, shifted left by FRAC_BITS, to the accumulator.
REQ-033 In the OUT state the output SHALL equal acc[DATA_WIDTH+FRAC_BITS-1:FRAC_BITS], saturated to the signed DATA_WIDTH range.
REQ-034 With ReLU selected, a negative output SHALL be forced to 0.
REQ-035 out_valid SHALL rise exactly 4 cycles after the edge that accepts the last input.
REQ-036 While out_ready is low, out_valid and out_data SHALL hold.
REQ-037 The accumulator and input count SHALL clear on OUT->IDLE, so back-to-back inferences need no reset.
REQ-038 Gaps in in_valid during ACCUM SHALL stall the count without corrupting the sum.

Reset
REQ-039 When rst is low at a clock edge, the block SHALL enter IDLE and clear the accumulator, the input count, the weight write pointer, the product register and out_valid.
REQ-040 On reset, out_data SHALL be 0 and in_ready SHALL be 0 while rst is low, then 1 in IDLE.
REQ-041 Weight memory and bias register contents SHALL be unaffected by reset.
REQ-042 A reset asserted mid-inference SHALL discard the partial sum; the next accepted input counts as index 0.

Verification
REQ-043 Bench SHALL cover: NUM_WEIGHT=4, weights 0x0100, bias 0x0080, inputs 0x0100 -> out_data 0x0480 with out_valid rising 4 cycles after the last accept.
REQ-044 Bench SHALL cover: weights 0xFF00, bias 0, inputs 0x0100 -> act_sel=0 gives 0x0000; act_sel=1 gives 0xFC00.
REQ-045 Bench SHALL cover: weights 0x7FFF, inputs 0x7FFF, NUM_WEIGHT=4 -> accumulator 0x7FFFFFFF, out_data 0x7FFF; negative mirror -> 0x8000.
REQ-046 Bench SHALL cover: out_ready held low 5 cycles -> out_data and out_valid stable with in_ready=0; release -> IDLE, and the next inference is correct.
REQ-047 Bench SHALL cover: weight_valid with config_neuron_num != NEURON_NO -> memory unchanged, result identical to the pre-write result.
REQ-048 Bench SHALL cover: rst low after 2 of 4 inputs, then 4 fresh inputs -> result equals the clean-run result, and the weights are retained.

Source files
------------

// File: rtl/neuron_mac_gen_if.sv
// Handshake and configuration bus of a single MAC neuron.
// master drives writes, activations and out_ready; slave is the neuron.
interface neuron_mac_gen_if #(
  parameter int DATA_WIDTH = 16
);
  logic                         weight_valid;
  logic                         bias_valid;
  logic [31:0]                  weight_value;
  logic [31:0]                  bias_value;
  logic [31:0]                  config_layer_num;
  logic [31:0]                  config_neuron_num;
  logic                         act_sel;
  logic signed [DATA_WIDTH-1:0] in_data;
  logic                         in_valid;
  logic                         in_ready;
  logic signed [DATA_WIDTH-1:0] out_data;
  logic                         out_valid;
  logic                         out_ready;

  modport master (
    output weight_valid, bias_valid, weight_value, bias_value,
           config_layer_num, config_neuron_num, act_sel,
           in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  weight_valid, bias_valid, weight_value, bias_value,
           config_layer_num, config_neuron_num, act_sel,
           in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/neuron_mac_gen.sv
// Fixed-point neuron: streams NUM_WEIGHT inputs through a pipelined saturating
// MAC, adds a bias, applies ReLU or linear activation and holds the result.
module neuron_mac_gen #(
  parameter int LAYER_NO   = 1,
  parameter int NEURON_NO  = 0,
  parameter int NUM_WEIGHT = 30,
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8
) (
  input logic             clk,
  input logic             rst,
  neuron_mac_gen_if.slave bus
);

  localparam int AW = 2 * DATA_WIDTH;
  localparam int CW = (NUM_WEIGHT > 1) ? $clog2(NUM_WEIGHT) : 1;
  localparam logic [CW-1:0] LAST = CW'(NUM_WEIGHT - 1);
  localparam logic signed [AW-1:0] ACC_MAX = {1'b0, {(AW-1){1'b1}}};
  localparam logic signed [AW-1:0] ACC_MIN = {1'b1, {(AW-1){1'b0}}};
  localparam logic signed [DATA_WIDTH-1:0] OUT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] OUT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, ACCUM, DRAIN, BIAS, OUT} state_t;

  state_t                       state, state_next;
  logic signed [DATA_WIDTH-1:0] weight_mem [NUM_WEIGHT];
  logic signed [DATA_WIDTH-1:0] bias_reg;
  logic [CW-1:0]                wptr, count;
  logic                         drain_cnt;
  logic signed [AW-1:0]         prod, acc, bias_ext;
  logic                         prod_valid;
  logic                         cfg_hit, weight_we, bias_we, accept, out_fire;
  logic signed [DATA_WIDTH-1:0] result, out_data_q;
  logic                         out_valid_q;

  function automatic logic signed [AW-1:0] sat_add(input logic signed [AW-1:0] a,
                                                   input logic signed [AW-1:0] b);
    logic [AW:0] s;
    s = {a[AW-1], a} + {b[AW-1], b};
    if (s[AW] != s[AW-1]) return s[AW] ? ACC_MIN : ACC_MAX;
    return s[AW-1:0];
  endfunction

  assign cfg_hit   = (bus.config_layer_num == 32'(LAYER_NO)) &&
                     (bus.config_neuron_num == 32'(NEURON_NO));
  assign weight_we = rst && bus.weight_valid && cfg_hit;
  assign bias_we   = rst && bus.bias_valid && cfg_hit;

  assign bus.in_ready  = rst && (state == IDLE || state == ACCUM);
  assign accept        = bus.in_valid && bus.in_ready;
  assign out_fire      = (state == OUT) && out_valid_q && bus.out_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

  assign bias_ext = {{(AW-DATA_WIDTH){bias_reg[DATA_WIDTH-1]}}, bias_reg} <<< FRAC_BITS;

  // Coefficient storage survives reset; only the write pointer is cleared.
  always_ff @(posedge clk) begin
    if (weight_we) weight_mem[wptr] <= bus.weight_value[DATA_WIDTH-1:0];
    if (bias_we)   bias_reg         <= bus.bias_value[DATA_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr <= '0;
    end else if (weight_we) begin
      wptr <= (wptr == LAST) ? '0 : wptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept) state_next = (count == LAST) ? DRAIN : ACCUM;
      ACCUM:   if (accept && count == LAST) state_next = DRAIN;
      DRAIN:   if (drain_cnt) state_next = BIAS;
      BIAS:    state_next = OUT;
      OUT:     if (out_fire) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Take bits [DATA_WIDTH+FRAC_BITS-1:FRAC_BITS]; anything above must be pure sign.
  always_comb begin
    result = acc[DATA_WIDTH+FRAC_BITS-1:FRAC_BITS];
    if (acc[AW-1:DATA_WIDTH+FRAC_BITS-1] != '0 &&
        acc[AW-1:DATA_WIDTH+FRAC_BITS-1] != '1)
      result = acc[AW-1] ? OUT_MIN : OUT_MAX;
    if (!bus.act_sel && result[DATA_WIDTH-1])
      result = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc         <= '0;
      count       <= '0;
      prod        <= '0;
      prod_valid  <= 1'b0;
      drain_cnt   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      prod_valid <= accept;
      drain_cnt  <= (state == DRAIN) ? ~drain_cnt : 1'b0;
      if (accept) begin
        prod  <= AW'(bus.in_data) * AW'(weight_mem[count]);
        count <= (count == LAST) ? '0 : count + 1'b1;
      end
      // The last product lands during DRAIN, so it never collides with the bias add.
      if (out_fire) begin
        acc         <= '0;
        count       <= '0;
        out_valid_q <= 1'b0;
      end else if (state == BIAS) begin
        acc <= sat_add(acc, bias_ext);
      end else if (prod_valid) begin
        acc <= sat_add(acc, prod);
      end
      if (state == OUT && !out_valid_q) begin
        out_valid_q <= 1'b1;
        out_data_q  <= result;
      end
    end
  end

endmodule

// File: tb/tb_neuron_mac_gen.sv
// Self-checking bench for neuron_mac_gen with NUM_WEIGHT=4, directed and random
// inferences compared against an arithmetic reference model.
module tb_neuron_mac_gen;
  localparam int DW = 16;
  localparam int NW = 4;
  localparam longint A_MAX = 64'sd2147483647;
  localparam longint A_MIN = -64'sd2147483648;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  neuron_mac_gen_if #(.DATA_WIDTH(DW)) bif();

  neuron_mac_gen #(
    .LAYER_NO(1), .NEURON_NO(0), .NUM_WEIGHT(NW), .DATA_WIDTH(DW), .FRAC_BITS(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bif)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic signed [15:0] m_w [NW];
  logic signed [15:0] m_b;
  int                 m_wp;
  logic signed [15:0] xin [NW];
  logic [15:0]        wstage [NW];

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic longint clamp(input longint v, input longint lo, input longint hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic void model(input bit act, output logic [15:0] o, output logic [31:0] a);
    longint acc = 0;
    longint r;
    for (int i = 0; i < NW; i++)
      acc = clamp(acc + longint'(m_w[i]) * longint'(xin[i]), A_MIN, A_MAX);
    acc = clamp(acc + longint'(m_b) * 256, A_MIN, A_MAX);
    r = clamp(acc >>> 8, -32768, 32767);
    if (!act && r < 0) r = 0;
    o = 16'(r);
    a = 32'(acc);
  endfunction

  task automatic idle_bus();
    bif.weight_valid = 0; bif.bias_valid = 0;
    bif.weight_value = '0; bif.bias_value = '0;
    bif.config_layer_num = '0; bif.config_neuron_num = '0;
    bif.act_sel = 1; bif.in_data = '0; bif.in_valid = 0; bif.out_ready = 0;
  endtask

  task automatic write_weight(input logic [15:0] v, input int layer, input int neuron);
    @(negedge clk);
    bif.weight_valid = 1;
    bif.weight_value = {16'($urandom), v};
    bif.config_layer_num = 32'(layer);
    bif.config_neuron_num = 32'(neuron);
    @(negedge clk);
    bif.weight_valid = 0;
    if (layer == 1 && neuron == 0) begin
      m_w[m_wp] = v;
      m_wp = (m_wp + 1) % NW;
    end
  endtask

  task automatic write_bias(input logic [15:0] v, input int layer, input int neuron);
    @(negedge clk);
    bif.bias_valid = 1;
    bif.bias_value = {16'($urandom), v};
    bif.config_layer_num = 32'(layer);
    bif.config_neuron_num = 32'(neuron);
    @(negedge clk);
    bif.bias_valid = 0;
    if (layer == 1 && neuron == 0) m_b = v;
  endtask

  task automatic load_weights();
    for (int i = 0; i < NW; i++) write_weight(wstage[i], 1, 0);
  endtask

  task automatic infer(input bit act, input bit gaps, input int hold,
                       output logic [15:0] got, output logic [31:0] acc_seen);
    int k, guard, acc_edge, lat;
    k = 0; guard = 0; acc_edge = 0;
    bif.act_sel = act;
    bif.out_ready = 0;
    while (k < NW && guard < 200) begin
      @(negedge clk);
      guard++;
      if (gaps && $urandom_range(0, 2) == 0) begin
        bif.in_valid = 0;
      end else begin
        bif.in_valid = 1;
        bif.in_data = xin[k];
        if (bif.in_ready) begin
          acc_edge = cyc + 1;
          k++;
        end
      end
    end
    @(negedge clk);
    bif.in_valid = 0;
    bif.in_data = 16'($urandom);
    checks++;
    if (k != NW) begin
      errors++;
      $display("FAIL accept_count got %0d want %0d", k, NW);
    end
    guard = 0;
    while (!bif.out_valid && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    lat = cyc - acc_edge;
    checks++;
    if (bif.out_valid !== 1'b1 || lat != 4) begin
      errors++;
      $display("FAIL out_valid_latency got %0d (out_valid=%b) want 4", lat, bif.out_valid);
    end
    got = bif.out_data;
    acc_seen = dut.acc;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      checks++;
      if (bif.out_valid !== 1'b1) begin
        errors++; $display("FAIL hold_out_valid cycle %0d got %b want 1", h, bif.out_valid);
      end
      checks++;
      if (bif.out_data !== got) begin
        errors++; $display("FAIL hold_out_data cycle %0d got %h want %h", h, bif.out_data, got);
      end
      checks++;
      if (bif.in_ready !== 1'b0) begin
        errors++; $display("FAIL hold_in_ready cycle %0d got %b want 0", h, bif.in_ready);
      end
    end
    bif.out_ready = 1;
    @(negedge clk);
    bif.out_ready = 0;
    checks++;
    if (bif.out_valid !== 1'b0 || bif.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL release out_valid=%b in_ready=%b want 0/1", bif.out_valid, bif.in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (bif.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", bif.in_ready); end
    checks++;
    if (bif.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bif.out_valid); end
    checks++;
    if (bif.out_data !== 16'h0000) begin errors++; $display("FAIL reset_out_data got %h want 0000", bif.out_data); end
    rst = 1;
    m_wp = 0;
    @(negedge clk);
    checks++;
    if (bif.in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready got %b want 1", bif.in_ready); end
  endtask

  task automatic test_basic();
    logic [15:0] got; logic [31:0] a;
    for (int i = 0; i < NW; i++) begin wstage[i] = 16'h0100; xin[i] = 16'h0100; end
    load_weights();
    write_bias(16'h0080, 1, 0);
    for (int act = 0; act < 2; act++) begin
      infer(act[0], 0, 0, got, a);
      checks++;
      if (got !== 16'h0480) begin errors++; $display("FAIL basic act=%0d got %h want 0480", act, got); end
    end
  endtask

  task automatic test_relu();
    logic [15:0] got; logic [31:0] a;
    for (int i = 0; i < NW; i++) begin wstage[i] = 16'hFF00; xin[i] = 16'h0100; end
    load_weights();
    write_bias(16'h0000, 1, 0);
    infer(0, 0, 0, got, a);
    checks++;
    if (got !== 16'h0000) begin errors++; $display("FAIL relu got %h want 0000", got); end
    infer(1, 0, 0, got, a);
    checks++;
    if (got !== 16'hFC00) begin errors++; $display("FAIL linear_neg got %h want fc00", got); end
  endtask

  task automatic test_saturation();
    logic [15:0] got; logic [31:0] a;
    for (int i = 0; i < NW; i++) begin wstage[i] = 16'h7FFF; xin[i] = 16'h7FFF; end
    load_weights();
    write_bias(16'h0000, 1, 0);
    infer(1, 0, 0, got, a);
    checks++;
    if (got !== 16'h7FFF) begin errors++; $display("FAIL sat_pos_out got %h want 7fff", got); end
    checks++;
    if (a !== 32'h7FFFFFFF) begin errors++; $display("FAIL sat_pos_acc got %h want 7fffffff", a); end
    for (int i = 0; i < NW; i++) wstage[i] = 16'h8001;
    load_weights();
    infer(1, 0, 0, got, a);
    checks++;
    if (got !== 16'h8000) begin errors++; $display("FAIL sat_neg_out got %h want 8000", got); end
    checks++;
    if (a !== 32'h80000000) begin errors++; $display("FAIL sat_neg_acc got %h want 80000000", a); end
  endtask

  task automatic test_backpressure();
    logic [15:0] got, exp; logic [31:0] a, ea;
    for (int i = 0; i < NW; i++) begin wstage[i] = 16'($urandom); xin[i] = 16'($urandom); end
    load_weights();
    write_bias(16'($urandom), 1, 0);
    model(1, exp, ea);
    infer(1, 0, 5, got, a);
    checks++;
    if (got !== exp) begin errors++; $display("FAIL backpressure got %h want %h", got, exp); end
    for (int i = 0; i < NW; i++) xin[i] = 16'($urandom);
    model(1, exp, ea);
    infer(1, 0, 0, got, a);
    checks++;
    if (got !== exp) begin errors++; $display("FAIL after_backpressure got %h want %h", got, exp); end
  endtask

  task automatic test_bad_write();
    logic [15:0] r1, r2, exp; logic [31:0] a, ea;
    for (int i = 0; i < NW; i++) begin wstage[i] = 16'($urandom_range(0, 16'h0FFF)); xin[i] = 16'($urandom); end
    load_weights();
    write_bias(16'($urandom_range(0, 255)), 1, 0);
    infer(1, 0, 0, r1, a);
    write_weight(16'($urandom), 1, 1);
    write_weight(16'($urandom), 2, 0);
    write_bias(16'($urandom), 1, 1);
    model(1, exp, ea);
    infer(1, 0, 0, r2, a);
    checks++;
    if (r2 !== r1) begin errors++; $display("FAIL bad_write_same got %h want %h", r2, r1); end
    checks++;
    if (r2 !== exp) begin errors++; $display("FAIL bad_write_model got %h want %h", r2, exp); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] clean, got, exp; logic [31:0] a, ea;
    for (int i = 0; i < NW; i++) begin wstage[i] = 16'($urandom); xin[i] = 16'($urandom); end
    load_weights();
    write_bias(16'($urandom), 1, 0);
    model(1, exp, ea);
    infer(1, 0, 0, clean, a);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      bif.in_valid = 1;
      bif.in_data = 16'($urandom);
    end
    @(negedge clk);
    bif.in_valid = 0;
    rst = 0;
    @(negedge clk);
    checks++;
    if (bif.in_ready !== 1'b0) begin errors++; $display("FAIL mid_reset_in_ready got %b want 0", bif.in_ready); end
    rst = 1;
    m_wp = 0;
    infer(1, 0, 0, got, a);
    checks++;
    if (got !== clean) begin errors++; $display("FAIL reset_mid_clean got %h want %h", got, clean); end
    checks++;
    if (got !== exp) begin errors++; $display("FAIL reset_mid_model got %h want %h", got, exp); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] got, exp; logic [31:0] a, ea;
    for (int n = 0; n < 3; n++) begin
      for (int i = 0; i < NW; i++) xin[i] = 16'($urandom);
      model(n[0], exp, ea);
      infer(n[0], 0, 0, got, a);
      checks++;
      if (got !== exp) begin errors++; $display("FAIL back_to_back #%0d got %h want %h", n, got, exp); end
    end
  endtask

  task automatic test_random();
    logic [15:0] got, exp; logic [31:0] a, ea;
    bit act;
    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < NW; i++) begin
        wstage[i] = (n < 4) ? 16'($urandom) : 16'($signed(12'($urandom)));
        xin[i] = 16'($urandom);
      end
      load_weights();
      write_bias(16'($urandom), 1, 0);
      act = 1'($urandom);
      model(act, exp, ea);
      infer(act, 1, $urandom_range(0, 2), got, a);
      checks++;
      if (got !== exp) begin errors++; $display("FAIL random #%0d act=%0d got %h want %h", n, act, got, exp); end
      checks++;
      if (a !== ea) begin errors++; $display("FAIL random_acc #%0d got %h want %h", n, a, ea); end
    end
  endtask

  initial begin
    idle_bus();
    m_wp = 0;
    m_b = '0;
    for (int i = 0; i < NW; i++) m_w[i] = '0;
    test_reset();
    test_basic();
    test_relu();
    test_saturation();
    test_backpressure();
    test_bad_write();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
